// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: two writeback sources (valid/ready/addr/data) and
// the registered register-file write port plus status outputs.
//   master : source/observer side (drives sN_valid/addr/data, sees everything else)
//   slave  : arbiter side (drives sN_ready, rf_we/wa/wd, pending, idle, wr_count)
interface wb_arbiter_if;
  logic        s0_valid;
  logic        s0_ready;
  logic [4:0]  s0_addr;
  logic [31:0] s0_data;
  logic        s1_valid;
  logic        s1_ready;
  logic [4:0]  s1_addr;
  logic [31:0] s1_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] pending;
  logic        idle;
  logic [15:0] wr_count;

  modport master (
    output s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
    input  s0_ready, s1_ready, rf_we, rf_wa, rf_wd, pending, idle, wr_count
  );

  modport slave (
    input  s0_valid, s0_addr, s0_data, s1_valid, s1_addr, s1_data,
    output s0_ready, s1_ready, rf_we, rf_wa, rf_wd, pending, idle, wr_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two sources (0 = ALU, 1 = LSU) each feed a DEPTH-entry
// FIFO; one head per cycle is popped round-robin onto a registered reg_file
// write port. Writes to x0 are accepted and discarded.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - wb_arbiter_if.slave: source handshakes, rf_we/rf_wa/rf_wd,
//           pending scoreboard, idle, wr_count
module wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input logic        clk,
  input logic        rst_n,
  wb_arbiter_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Queue storage and pointers, indexed by source
  logic [4:0]    q_addr_q [2][DEPTH];
  logic [31:0]   q_data_q [2][DEPTH];
  logic [AW-1:0] wptr_q   [2];
  logic [AW-1:0] rptr_q   [2];
  logic [CW-1:0] cnt_q    [2];

  logic        prio_q;
  logic        rf_we_q;
  logic [4:0]  rf_wa_q;
  logic [31:0] rf_wd_q;
  logic [15:0] wr_count_q;

  logic        src_valid [2];
  logic [4:0]  src_addr  [2];
  logic [31:0] src_data  [2];
  logic        ready     [2];
  logic        push      [2];
  logic        nonempty  [2];
  logic        grant     [2];
  logic        win;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic [31:0] pending;

  always_comb begin
    src_valid[0] = bus.s0_valid;
    src_valid[1] = bus.s1_valid;
    src_addr[0]  = bus.s0_addr;
    src_addr[1]  = bus.s1_addr;
    src_data[0]  = bus.s0_data;
    src_data[1]  = bus.s1_data;
    for (int s = 0; s < 2; s++) begin
      // Ready is a function of registered occupancy only, so a slot freed by
      // this cycle's pop is not reusable until the next cycle.
      ready[s]    = rst_n & (cnt_q[s] != CW'(DEPTH));
      push[s]     = src_valid[s] & ready[s] & (src_addr[s] != 5'd0);
      nonempty[s] = (cnt_q[s] != '0);
    end
    grant[0]  = nonempty[0] & (~nonempty[1] | ~prio_q);
    grant[1]  = nonempty[1] & ~grant[0];
    win       = grant[1];
    head_addr = q_addr_q[win][rptr_q[win]];
    head_data = q_data_q[win][rptr_q[win]];
  end

  // Scoreboard of destinations still owed a write: live queue entries plus
  // the write currently on the rf port.
  always_comb begin : pending_calc
    logic [AW-1:0] offs;
    offs    = '0;
    pending = '0;
    if (rf_we_q) pending[rf_wa_q] = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        offs = AW'(i) - rptr_q[s];
        if (CW'(offs) < cnt_q[s]) pending[q_addr_q[s][i]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

  // Entry storage needs no reset; occupancy decides what is live.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        q_addr_q[s][wptr_q[s]] <= src_addr[s];
        q_data_q[s][wptr_q[s]] <= src_data[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      prio_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
      wr_count_q <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s])  wptr_q[s] <= wptr_q[s] + AW'(1);
        if (grant[s]) rptr_q[s] <= rptr_q[s] + AW'(1);
        cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(grant[s]);
      end
      rf_we_q <= grant[0] | grant[1];
      if (grant[0] | grant[1]) begin
        rf_wa_q    <= head_addr;
        rf_wd_q    <= head_data;
        prio_q     <= ~win;
        wr_count_q <= wr_count_q + 16'd1;
      end
    end
  end

  assign bus.s0_ready = ready[0];
  assign bus.s1_ready = ready[1];
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_wa    = rf_wa_q;
  assign bus.rf_wd    = rf_wd_q;
  assign bus.pending  = pending;
  assign bus.idle     = ~nonempty[0] & ~nonempty[1] & ~rf_we_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH = 2) with hand-computed expectations.
module tb_wb_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [31:0] rf_model [32];

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference register file fed from the arbiter's write port
  always @(posedge clk) begin
    if (bus.rf_we) rf_model[bus.rf_wa] <= bus.rf_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s0_valid = 1'b0;
    bus.s0_addr  = '0;
    bus.s0_data  = '0;
    bus.s1_valid = 1'b0;
    bus.s1_addr  = '0;
    bus.s1_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.s0_valid = v0;
    bus.s0_addr  = a0;
    bus.s0_data  = d0;
    bus.s1_valid = v1;
    bus.s1_addr  = a1;
    bus.s1_data  = d1;
  endtask

  logic [4:0]  s0_tbl [3];
  logic [4:0]  s1_tbl [3];
  logic [4:0]  exp_ord [6];
  logic [4:0]  iss_wa [8];
  logic [31:0] iss_wd [8];
  int          n_iss;
  int          i0;
  int          i1;
  int          we_seen;
  logic        acc0;
  logic        acc1;
  logic        saw_full;

  initial begin
    n_checks = 0;
    n_errors = 0;
    s0_tbl   = '{5'd10, 5'd11, 5'd12};
    s1_tbl   = '{5'd3, 5'd4, 5'd5};
    exp_ord  = '{5'd10, 5'd3, 5'd11, 5'd4, 5'd12, 5'd5};
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("rst_s0_ready", 32'(bus.s0_ready), 32'd0);
    check("rst_s1_ready", 32'(bus.s1_ready), 32'd0);
    check("rst_idle", 32'(bus.idle), 32'd1);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_pending", bus.pending, 32'd0);
    check("rst_wr_count", 32'(bus.wr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single write x5
    drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    check("single_ready", 32'(bus.s0_ready), 32'd1);
    tick();
    idle_inputs();
    check("single_pend_q", bus.pending, 32'h0000_0020);
    check("single_we_early", 32'(bus.rf_we), 32'd0);
    check("single_busy", 32'(bus.idle), 32'd0);
    tick();
    check("single_we", 32'(bus.rf_we), 32'd1);
    check("single_wa", 32'(bus.rf_wa), 32'd5);
    check("single_wd", bus.rf_wd, 32'h1234_5678);
    check("single_pend_f", bus.pending, 32'h0000_0020);
    check("single_cnt", 32'(bus.wr_count), 32'd1);
    tick();
    check("single_we_off", 32'(bus.rf_we), 32'd0);
    check("single_pend_0", bus.pending, 32'd0);
    check("single_idle", 32'(bus.idle), 32'd1);

    // Contention after reset: source 0 first, next tie to source 0 again
    do_reset();
    drive(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222);
    tick();
    idle_inputs();
    check("cont_pend", bus.pending, 32'h0000_0006);
    tick();
    check("cont_wa1", 32'(bus.rf_wa), 32'd1);
    check("cont_wd1", bus.rf_wd, 32'h1111_1111);
    tick();
    check("cont_wa2", 32'(bus.rf_wa), 32'd2);
    check("cont_wd2", bus.rf_wd, 32'h2222_2222);
    check("cont_cnt2", 32'(bus.wr_count), 32'd2);
    drive(1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd4, 32'h4444_4444);
    tick();
    idle_inputs();
    tick();
    check("tie2_wa_first", 32'(bus.rf_wa), 32'd3);
    tick();
    check("tie2_wa_second", 32'(bus.rf_wa), 32'd4);
    tick();
    check("tie2_we_off", 32'(bus.rf_we), 32'd0);
    check("tie2_cnt", 32'(bus.wr_count), 32'd4);

    // x0 write is swallowed
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    check("x0_ready", 32'(bus.s0_ready), 32'd1);
    tick();
    idle_inputs();
    check("x0_pend", bus.pending, 32'd0);
    check("x0_idle", 32'(bus.idle), 32'd1);
    tick();
    check("x0_we", 32'(bus.rf_we), 32'd0);
    check("x0_cnt", 32'(bus.wr_count), 32'd4);

    // Lone source-0 write leaves prio = 1, then same-address tie
    drive(1'b1, 5'd8, 32'h8888_8888, 1'b0, 5'd0, 32'd0);
    tick();
    idle_inputs();
    tick();
    drive(1'b1, 5'd7, 32'hAAAA_AAAA, 1'b1, 5'd7, 32'h5555_5555);
    tick();
    idle_inputs();
    tick();
    check("same_wd_first", bus.rf_wd, 32'h5555_5555);
    tick();
    check("same_wd_second", bus.rf_wd, 32'hAAAA_AAAA);
    tick();
    check("same_rf_x7", rf_model[7], 32'hAAAA_AAAA);
    check("same_cnt", 32'(bus.wr_count), 32'd7);

    // Backpressure: both sources stream three writes into DEPTH = 2 queues
    do_reset();
    i0 = 0;
    i1 = 0;
    n_iss = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(i0 < 3, (i0 < 3) ? s0_tbl[i0] : 5'd0, 32'hC0DE_0000 | ((i0 < 3) ? 32'(s0_tbl[i0]) : 0),
            i1 < 3, (i1 < 3) ? s1_tbl[i1] : 5'd0, 32'hC0DE_0000 | ((i1 < 3) ? 32'(s1_tbl[i1]) : 0));
      acc0 = bus.s0_valid & bus.s0_ready;
      acc1 = bus.s1_valid & bus.s1_ready;
      if (bus.s1_valid && !bus.s1_ready) saw_full = 1'b1;
      tick();
      if (acc0) i0++;
      if (acc1) i1++;
      if (bus.rf_we) begin
        if (n_iss < 8) begin
          iss_wa[n_iss] = bus.rf_wa;
          iss_wd[n_iss] = bus.rf_wd;
        end
        n_iss++;
      end
    end
    idle_inputs();
    check("bp_s1_full_seen", 32'(saw_full), 32'd1);
    check("bp_s0_sent", i0, 3);
    check("bp_s1_sent", i1, 3);
    check("bp_issued", n_iss, 6);
    check("bp_cnt", 32'(bus.wr_count), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < n_iss) begin
        check($sformatf("bp_wa%0d", k), 32'(iss_wa[k]), 32'(exp_ord[k]));
        check($sformatf("bp_wd%0d", k), iss_wd[k], 32'hC0DE_0000 | 32'(exp_ord[k]));
      end
    end

    // Reset mid-flight with both queues loaded
    drive(1'b1, 5'd20, 32'h2020_2020, 1'b1, 5'd22, 32'h2222_0022);
    tick();
    drive(1'b1, 5'd21, 32'h2121_2121, 1'b1, 5'd23, 32'h2323_2323);
    tick();
    idle_inputs();
    check("mid_we_before", 32'(bus.rf_we), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_we", 32'(bus.rf_we), 32'd0);
    check("mid_pend", bus.pending, 32'd0);
    check("mid_cnt", 32'(bus.wr_count), 32'd0);
    check("mid_ready", 32'(bus.s0_ready), 32'd0);
    check("mid_idle", 32'(bus.idle), 32'd1);
    #1 rst_n = 1'b1;
    we_seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.rf_we) we_seen++;
    end
    check("mid_no_ghost", we_seen, 0);
    drive(1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 32'd0);
    tick();
    idle_inputs();
    tick();
    check("mid_new_we", 32'(bus.rf_we), 32'd1);
    check("mid_new_wa", 32'(bus.rf_wa), 32'd9);
    check("mid_new_wd", bus.rf_wd, 32'h9999_0009);
    check("mid_new_cnt", 32'(bus.wr_count), 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
